// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA timing generator.
// Optional feature macro: VGA_FRAME_COUNT_EN (frame counter output).
package vga_pkg;

    localparam int unsigned POS_W = 10;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned FCNT_W = 8;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } axis_state_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: pixel strobe in, position/sync/visible/pulses out.
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic             pix_en;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             hsync;
    logic             vsync;
    logic             visible;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [FCNT_W-1:0] frame_count;
`endif

    modport master (
        input  pix_en,
        output x, y, hsync, vsync, visible, line_start, frame_start
`ifdef VGA_FRAME_COUNT_EN
        , output frame_count
`endif
    );

    modport slave (
        output pix_en,
        input  x, y, hsync, vsync, visible, line_start, frame_start
`ifdef VGA_FRAME_COUNT_EN
        , input frame_count
`endif
    );

endinterface

// File: rtl/vga_axis_seq.sv
// One raster axis: segment FSM plus position counter, advancing on adv_i.
// Exposes the next state and the "at last position" flag combinationally.
module vga_axis_seq
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE_LEN = H_ACTIVE,
    parameter int unsigned FP_LEN     = H_FP,
    parameter int unsigned SYNC_LEN   = H_SYNC,
    parameter int unsigned BP_LEN     = H_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv_i,
    output logic [POS_W-1:0] pos_o,
    output axis_state_t      state_c_o,
    output logic             wrap_c_o
);

    localparam int unsigned ACT_END  = ACTIVE_LEN - 1;
    localparam int unsigned FP_END   = ACTIVE_LEN + FP_LEN - 1;
    localparam int unsigned SYNC_END = ACTIVE_LEN + FP_LEN + SYNC_LEN - 1;
    localparam int unsigned LAST     = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN - 1;

    axis_state_t      state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             at_last;

    assign at_last = (pos_q == POS_W'(LAST));

    // Reset parks the axis on its last position so the first advance lands on 0/ACTIVE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BACK;
            pos_q   <= POS_W'(LAST);
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        if (adv_i) begin
            pos_d = at_last ? '0 : pos_q + POS_W'(1);
            case (state_q)
                ACTIVE:  if (pos_q == POS_W'(ACT_END))  state_d = FRONT;
                FRONT:   if (pos_q == POS_W'(FP_END))   state_d = SYNC;
                SYNC:    if (pos_q == POS_W'(SYNC_END)) state_d = BACK;
                BACK:    if (at_last)                   state_d = ACTIVE;
                default:                                state_d = BACK;
            endcase
        end
    end

    assign pos_o     = pos_q;
    assign state_c_o = state_d;
    assign wrap_c_o  = at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two chained axis sequencers plus registered sync/visible/pulses.
// Define VGA_FRAME_COUNT_EN to add the 8-bit frame counter output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned P_H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned P_H_FP     = vga_pkg::H_FP,
    parameter int unsigned P_H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned P_H_BP     = vga_pkg::H_BP,
    parameter int unsigned P_V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned P_V_FP     = vga_pkg::V_FP,
    parameter int unsigned P_V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned P_V_BP     = vga_pkg::V_BP
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);

    logic             pix_en;
    logic [POS_W-1:0] h_pos, v_pos;
    axis_state_t      h_state_c, v_state_c;
    logic             h_wrap_c, v_wrap_c;
    logic             v_adv;

    assign pix_en = vga.pix_en;
    assign v_adv  = pix_en & h_wrap_c;

    vga_axis_seq #(
        .ACTIVE_LEN (P_H_ACTIVE),
        .FP_LEN     (P_H_FP),
        .SYNC_LEN   (P_H_SYNC),
        .BP_LEN     (P_H_BP)
    ) u_h_axis (
        .clk       (clk),
        .reset     (reset),
        .adv_i     (pix_en),
        .pos_o     (h_pos),
        .state_c_o (h_state_c),
        .wrap_c_o  (h_wrap_c)
    );

    vga_axis_seq #(
        .ACTIVE_LEN (P_V_ACTIVE),
        .FP_LEN     (P_V_FP),
        .SYNC_LEN   (P_V_SYNC),
        .BP_LEN     (P_V_BP)
    ) u_v_axis (
        .clk       (clk),
        .reset     (reset),
        .adv_i     (v_adv),
        .pos_o     (v_pos),
        .state_c_o (v_state_c),
        .wrap_c_o  (v_wrap_c)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic visible_q, visible_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;
`ifdef VGA_FRAME_COUNT_EN
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;
`endif

    // Decode from the axes' next state so the flags line up with the new x/y.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        visible_d     = visible_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
`ifdef VGA_FRAME_COUNT_EN
        frame_count_d = frame_count_q;
`endif
        if (pix_en) begin
            hsync_d       = (h_state_c != SYNC);
            vsync_d       = (v_state_c != SYNC);
            visible_d     = (h_state_c == ACTIVE) && (v_state_c == ACTIVE);
            line_start_d  = h_wrap_c;
            frame_start_d = h_wrap_c & v_wrap_c;
`ifdef VGA_FRAME_COUNT_EN
            if (h_wrap_c & v_wrap_c) frame_count_d = frame_count_q + FCNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            visible_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
            frame_count_q <= '0;
`endif
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            visible_q     <= visible_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_COUNT_EN
            frame_count_q <= frame_count_d;
`endif
        end
    end

    assign vga.x           = h_pos;
    assign vga.y           = v_pos;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.visible     = visible_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
`ifdef VGA_FRAME_COUNT_EN
    assign vga.frame_count = frame_count_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel strobe produced by the upstream clock-divider counter. Outputs the current pixel column/row, active-low hsync/vsync, the visible-region flag and line/frame start pulses. Consumed downstream by the snake renderer and game-tick logic. One FSM plus position counter per axis; vertical axis advances only on horizontal wrap.

## Interface
- H_ACTIVE, 640, visible columns
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible rows
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  one-clk pixel strobe; all state advances only when high
- x  out  10  current column, 0..H_TOTAL-1 (H_TOTAL = 800)
- y  out  10  current row, 0..V_TOTAL-1 (V_TOTAL = 525)
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- visible  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- line_start  out  1  one-clk pulse when x becomes 0
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)
- frame_count  out  8  frames since reset (only with VGA_FRAME_COUNT_EN)

## Operation
- Per-axis FSM states: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE; a state is left when its segment's last position is passed.
- Horizontal axis advances on every pix_en; x increments, wraps H_TOTAL-1 -> 0.
- Vertical axis advances on pix_en when x wraps; y increments, wraps V_TOTAL-1 -> 0.
- hsync = 0 exactly for x in 656..751 (SYNC state); vsync = 0 exactly for y in 490..491.
- visible = 1 only when both axis FSMs are in ACTIVE.
- Position arithmetic is 10-bit unsigned; no value outside 0..799 / 0..524 ever appears.
- pix_en low: x, y, states, hsync, vsync, visible hold; line_start/frame_start are 0.

## Timing
- All outputs registered; computed from next position so they are aligned with x/y in the same cycle (zero lag).
- Reset values: x = 799, y = 524, both FSMs in BACK, hsync = 1, vsync = 1, visible = 0, line_start = 0, frame_start = 0, frame_count = 0.
- First pix_en after reset release: x = 0, y = 0, visible = 1, line_start = 1, frame_start = 1.
- line_start/frame_start high for exactly one clk (the clk of the pix_en edge), regardless of pix_en period.
- Reset asserted mid-frame: immediate return to reset values; restart as above.
- Simultaneous x and y wrap (799,524 -> 0,0): both FSMs enter ACTIVE on the same edge; frame_start and line_start both pulse.

## Configuration
- VGA_FRAME_COUNT_EN defined: frame_count port exists; increments by 1 on each frame_start edge, wraps 255 -> 0, reset 0. Used for game-tick pacing.
- Not defined: frame_count port and its register are absent; all other behaviour identical.

## Structure
- Package vga_pkg: axis_state_t enum {ACTIVE, FRONT, SYNC, BACK}; default 640x480 timing constants; H_TOTAL/V_TOTAL derived constants; POS_W = 10.
- Sub-module vga_axis_seq: one axis FSM + position counter, parameterised by segment lengths, inputs adv, outputs pos, state, wrap; instantiated twice (vertical adv = pix_en & horizontal wrap).

## Test plan
- Reset release, pulse pix_en once -> x = 0, y = 0, visible = 1, line_start = frame_start = 1 for one clk.
- Step 656 pix_en from (0,0) -> hsync falls at x = 656, rises at x = 752, visible = 0 from x = 640.
- Run full line -> x 799 -> 0, y 0 -> 1, line_start = 1, frame_start = 0.
- Run full frame -> vsync low only for y = 490..491; frame_start after 420000 pix_en; (799,524) -> (0,0).
- pix_en held low 50 clks mid-line -> all outputs unchanged, no pulses; then resumes from same x.
- Reset asserted at (300,200), VGA_FRAME_COUNT_EN with frame_count = 3 -> x = 799, y = 524, visible = 0, frame_count = 0 asynchronously.
